// File: rtl/tile_config_mem_shadow.sv
// Double-buffered tile configuration memory: one-hot framed writes fill a shadow store,
// Commit copies it to ConfigBits/ConfigBits_N, and a handshaked port streams shadow frames back.
// Optional build macro CONFIG_MEM_PARITY_EN gates frame writes on even parity of FrameData.
module tile_config_mem_shadow #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigBits    = 64
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  input  logic                       FrameParity,
  input  logic                       Commit,
  input  logic                       RbStart,
  input  logic                       RbReady,
  output logic                       RbValid,
  output logic [FrameBitsPerRow-1:0] RbData,
  output logic                       RbLast,
  output logic                       StrobeError,
  output logic                       ParityError,
  output logic [NoConfigBits-1:0]    ConfigBits,
  output logic [NoConfigBits-1:0]    ConfigBits_N
);

  localparam int TOTAL_BITS = MaxFramesPerCol * FrameBitsPerRow;
  localparam int IDX_W      = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;

  typedef enum logic {
    IDLE,
    STREAM
  } rb_state_t;

  function automatic logic is_multi_hot(input logic [MaxFramesPerCol-1:0] s);
    return |(s & (s - MaxFramesPerCol'(1)));
  endfunction

  logic                       strobe_any;
  logic                       strobe_multi;
  logic                       strobe_onehot;
  logic                       par_ok;
  logic                       wr_en;
  logic [NoConfigBits-1:0]    shadow_p0;
  logic [NoConfigBits-1:0]    shadow_nxt;
  logic [NoConfigBits-1:0]    active_p1;
  logic [NoConfigBits-1:0]    active_n_p1;
  logic [TOTAL_BITS-1:0]      shadow_pad;
  logic [FrameBitsPerRow-1:0] frames [MaxFramesPerCol];
  rb_state_t                  state_q;
  rb_state_t                  state_nxt;
  logic [IDX_W-1:0]           idx_q;
  logic [IDX_W-1:0]           idx_nxt;
  logic                       rb_valid;
  logic                       rb_last;
  logic                       strobe_err_q;

  assign strobe_any    = |FrameStrobe;
  assign strobe_multi  = is_multi_hot(FrameStrobe);
  assign strobe_onehot = strobe_any & ~strobe_multi;

`ifdef CONFIG_MEM_PARITY_EN
  logic parity_err_q;

  assign par_ok = ((^FrameData) == FrameParity);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      parity_err_q <= 1'b0;
    end else if (strobe_onehot && !par_ok) begin
      parity_err_q <= 1'b1;
    end
  end

  assign ParityError = parity_err_q;
`else
  logic unused_parity;

  assign unused_parity = FrameParity;
  assign par_ok        = 1'b1;
  assign ParityError   = 1'b0;
`endif

  assign wr_en = strobe_onehot & par_ok;

  // Shadow stage (p0): only mapped bits exist, each tied to its frame strobe and row bit
  for (genvar g = 0; g < NoConfigBits; g++) begin : g_bit
    assign shadow_nxt[g] = (wr_en && FrameStrobe[g / FrameBitsPerRow])
                         ? FrameData[g % FrameBitsPerRow]
                         : shadow_p0[g];
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      shadow_p0    <= '0;
      strobe_err_q <= 1'b0;
    end else begin
      shadow_p0 <= shadow_nxt;
      if (strobe_multi) begin
        strobe_err_q <= 1'b1;
      end
    end
  end

  assign StrobeError = strobe_err_q;

  // Active stage (p1): takes the pre-edge shadow, so a same-edge write waits for the next Commit
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      active_p1   <= '0;
      active_n_p1 <= '1;
    end else if (Commit) begin
      active_p1   <= shadow_p0;
      active_n_p1 <= ~shadow_p0;
    end
  end

  assign ConfigBits   = active_p1;
  assign ConfigBits_N = active_n_p1;

  // Readback view: unmapped tail of the last frames reads as zero
  assign shadow_pad = TOTAL_BITS'(shadow_p0);

  for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_frame
    assign frames[f] = shadow_pad[f*FrameBitsPerRow +: FrameBitsPerRow];
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
    end
  end

  assign rb_last = (state_q == STREAM) && (idx_q == IDX_W'(MaxFramesPerCol - 1));

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    rb_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (RbStart) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
        end
      end
      STREAM: begin
        rb_valid = 1'b1;
        if (RbReady) begin
          if (rb_last) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign RbValid = rb_valid;
  assign RbLast  = rb_last;
  assign RbData  = rb_valid ? frames[idx_q] : '0;

endmodule

// File: tb/tb_tile_config_mem_shadow.sv
// Scoreboard bench for tile_config_mem_shadow: directed frame/commit/readback vectors,
// with a negedge monitor checking every presented readback beat against a queue.
module tb_tile_config_mem_shadow;

  localparam int MF = 20;
  localparam int FB = 32;
  localparam int NB = 64;

  logic          clk = 1'b0;
  logic          resetn;
  logic [FB-1:0] FrameData;
  logic [MF-1:0] FrameStrobe;
  logic          FrameParity;
  logic          Commit;
  logic          RbStart;
  logic          RbReady;
  logic          RbValid;
  logic [FB-1:0] RbData;
  logic          RbLast;
  logic          StrobeError;
  logic          ParityError;
  logic [NB-1:0] ConfigBits;
  logic [NB-1:0] ConfigBits_N;

  int vectors     = 0;
  int miscompares = 0;
  logic [FB:0] exp_q[$];

  always #5 clk = ~clk;

  tile_config_mem_shadow #(
    .MaxFramesPerCol(MF),
    .FrameBitsPerRow(FB),
    .NoConfigBits   (NB)
  ) dut (
    .CLK         (clk),
    .resetn      (resetn),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .FrameParity (FrameParity),
    .Commit      (Commit),
    .RbStart     (RbStart),
    .RbReady     (RbReady),
    .RbValid     (RbValid),
    .RbData      (RbData),
    .RbLast      (RbLast),
    .StrobeError (StrobeError),
    .ParityError (ParityError),
    .ConfigBits  (ConfigBits),
    .ConfigBits_N(ConfigBits_N)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input int f, input logic [FB-1:0] d, input logic par);
    FrameStrobe = MF'(1) << f;
    FrameData   = d;
    FrameParity = par;
    tick();
    FrameStrobe = '0;
  endtask

  task automatic do_commit();
    Commit = 1'b1;
    tick();
    Commit = 1'b0;
  endtask

  task automatic push_sweep(input int n, input logic [FB-1:0] f0, input logic [FB-1:0] f1);
    for (int i = 0; i < n; i++) begin
      logic [FB-1:0] d;
      d = (i == 0) ? f0 : (i == 1) ? f1 : '0;
      exp_q.push_back({(i == MF - 1) ? 1'b1 : 1'b0, d});
    end
  endtask

  // Monitor: every beat on offer is compared; the head is popped only on a transfer
  always @(negedge clk) begin
    if (resetn === 1'b1 && RbValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        if (RbReady) chk("unexpected_beat", 64'(RbData), 64'hDEAD);
      end else begin
        chk("rb_data", 64'(RbData), 64'(exp_q[0][FB-1:0]));
        chk("rb_last", 64'(RbLast), 64'(exp_q[0][FB]));
        if (RbReady) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn      = 1'b0;
    FrameData   = '0;
    FrameStrobe = '0;
    FrameParity = 1'b0;
    Commit      = 1'b0;
    RbStart     = 1'b0;
    RbReady     = 1'b0;
    repeat (3) tick();
    chk("rst_cfg",      ConfigBits,   64'h0);
    chk("rst_cfg_n",    ConfigBits_N, {64{1'b1}});
    chk("rst_valid",    64'(RbValid), 64'h0);
    chk("rst_last",     64'(RbLast),  64'h0);
    chk("rst_data",     64'(RbData),  64'h0);
    chk("rst_strb_err", 64'(StrobeError), 64'h0);
    chk("rst_par_err",  64'(ParityError), 64'h0);
    resetn = 1'b1;
    tick();

    // Load frames 0 and 1 without commit, then commit
    write_frame(0, 32'hA5A5_0001, ^32'hA5A5_0001);
    write_frame(1, 32'h0000_00FF, ^32'h0000_00FF);
    tick();
    chk("precommit_cfg",   ConfigBits,   64'h0);
    chk("precommit_cfg_n", ConfigBits_N, {64{1'b1}});
    do_commit();
    chk("commit_cfg",   ConfigBits,   64'h0000_00FF_A5A5_0001);
    chk("commit_cfg_n", ConfigBits_N, ~64'h0000_00FF_A5A5_0001);

    // Same-edge write and commit: active keeps the old frame 0
    FrameStrobe = MF'(1);
    FrameData   = 32'h1234_5678;
    FrameParity = ^32'h1234_5678;
    Commit      = 1'b1;
    tick();
    FrameStrobe = '0;
    Commit      = 1'b0;
    chk("same_edge_cfg", ConfigBits, 64'h0000_00FF_A5A5_0001);
    do_commit();
    chk("second_commit_cfg", ConfigBits, 64'h0000_00FF_1234_5678);

    // Multi-hot strobe: no write, sticky error
    FrameStrobe = 20'h00003;
    FrameData   = 32'hFFFF_FFFF;
    FrameParity = 1'b0;
    tick();
    FrameStrobe = '0;
    chk("strb_err_set", 64'(StrobeError), 64'h1);
    repeat (10) tick();
    chk("strb_err_sticky", 64'(StrobeError), 64'h1);
    do_commit();
    chk("multihot_no_write", ConfigBits, 64'h0000_00FF_1234_5678);

    // Full sweep with RbReady held high
    push_sweep(MF, 32'h1234_5678, 32'h0000_00FF);
    RbReady = 1'b1;
    RbStart = 1'b1;
    tick();
    RbStart = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("sweep_cycles", 64'(n), 64'd20);
    chk("sweep_idle", 64'(RbValid), 64'h0);

    // Sweep with RbReady toggling; RbStart raised with the final transfer is ignored
    push_sweep(MF, 32'h1234_5678, 32'h0000_00FF);
    RbStart = 1'b1;
    tick();
    RbStart = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      RbReady = ~RbReady;
      RbStart = RbReady && (exp_q.size() == 1);
      tick();
      n++;
    end
    RbStart = 1'b0;
    chk("toggle_cycles", 64'(n), 64'd40);
    chk("toggle_idle", 64'(RbValid), 64'h0);
    RbReady = 1'b1;
    tick();
    chk("late_start_ignored", 64'(RbValid), 64'h0);

    // Parity behaviour on frame 1
    write_frame(1, 32'h0000_0001, 1'b0);
    do_commit();
`ifdef CONFIG_MEM_PARITY_EN
    chk("parity_bad_no_write", ConfigBits, 64'h0000_00FF_1234_5678);
    chk("parity_err_set", 64'(ParityError), 64'h1);
`else
    chk("parity_ignored_write", ConfigBits, 64'h0000_0001_1234_5678);
    chk("parity_err_tied", 64'(ParityError), 64'h0);
`endif
    write_frame(1, 32'h0000_0001, 1'b1);
    do_commit();
    chk("parity_good_write", ConfigBits, 64'h0000_0001_1234_5678);

    // Reset in the middle of a sweep at idx 7
    push_sweep(7, 32'h1234_5678, 32'h0000_0001);
    RbReady = 1'b1;
    RbStart = 1'b1;
    tick();
    RbStart = 1'b0;
    repeat (7) tick();
    RbReady = 1'b0;
    chk("midsweep_drained", 64'(exp_q.size()), 64'h0);
    chk("midsweep_valid", 64'(RbValid), 64'h1);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_valid",    64'(RbValid), 64'h0);
    chk("abort_cfg",      ConfigBits,   64'h0);
    chk("abort_cfg_n",    ConfigBits_N, {64{1'b1}});
    chk("abort_strb_err", 64'(StrobeError), 64'h0);
    chk("abort_par_err",  64'(ParityError), 64'h0);
    tick();
    resetn = 1'b1;
    tick();

    write_frame(0, 32'hCAFE_F00D, ^32'hCAFE_F00D);
    write_frame(1, 32'h0000_BEEF, ^32'h0000_BEEF);
    chk("post_reset_cfg", ConfigBits, 64'h0);
    push_sweep(MF, 32'hCAFE_F00D, 32'h0000_BEEF);
    RbReady = 1'b1;
    RbStart = 1'b1;
    tick();
    RbStart = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("restart_cycles", 64'(n), 64'd20);
    repeat (3) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
